channel_error_injector: RTL and testbench

Parametrised channel impairment block placed between the convolutional encoder output and the Viterbi decoder input. It replaces fixed one-in-N bit flipping with a programmable injector. The injector supports pass-through, periodic, pseudo-random-per-window and burst modes, generic symbol width, and live injection statistics. It gives the decoder a repeatable, measurable error environment.

---
 rtl/channel_error_injector.sv | 133 +++++++++++++
 tb/tb_channel_error_injector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/channel_error_injector.sv
// rtl/channel_error_injector.sv - programmable symbol corruption between encoder and Viterbi decoder
module channel_error_injector #(
   parameter int          SYM_W     = 2,
   parameter int          WIN_LOG2  = 4,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                valid_i,
   input  logic [SYM_W-1:0]    sym_i,
   input  logic [1:0]          mode_i,
   input  logic [SYM_W-1:0]    bit_mask_i,
   input  logic [WIN_LOG2-1:0] burst_len_i,
   output logic                valid_o,
   output logic [SYM_W-1:0]    sym_o,
   output logic                err_o,
   output logic [CNT_W-1:0]    inj_count_o,
   output logic [CNT_W-1:0]    sym_count_o
);

   // An all-zero seed would lock the LFSR, so substitute the smallest live state.
   localparam logic [15:0]         SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [WIN_LOG2-1:0] POS_LAST = '1;
   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

   logic                valid_q, valid_d;
   logic [SYM_W-1:0]    sym_q, sym_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    inj_cnt_q, inj_cnt_d;
   logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic [WIN_LOG2-1:0] pos_q, pos_d;
   logic [1:0]          mode_q, mode_d;
   logic [WIN_LOG2-1:0] blen_q, blen_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [WIN_LOG2-1:0] target_q, target_d;

   logic                accept;
   logic                win_start;
   logic [1:0]          mode_eff;
   logic [WIN_LOG2-1:0] blen_eff;
   logic [WIN_LOG2-1:0] burst_off;
   logic                sel;
   logic                inject;
   logic [15:0]         lfsr_step;

   assign accept    = valid_i && !clr_i;
   assign win_start = (pos_q == '0);
   assign mode_eff  = win_start ? mode_i : mode_q;
   assign blen_eff  = win_start ? burst_len_i : blen_q;
   assign burst_off = pos_q - target_q;
   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   always_comb begin
      sel = 1'b0;
      case (mode_eff)
         2'd1:    sel = (pos_q == POS_LAST);
         2'd2:    sel = (pos_q == target_q);
         2'd3:    sel = (pos_q >= target_q) && (burst_off < blen_eff);
         default: sel = 1'b0;
      endcase
   end

   assign inject = accept && sel && (bit_mask_i != '0);

   always_comb begin
      valid_d   = valid_i;
      err_d     = inject;
      sym_d     = sym_q;
      inj_cnt_d = inj_cnt_q;
      sym_cnt_d = sym_cnt_q;
      pos_d     = pos_q;
      mode_d    = mode_q;
      blen_d    = blen_q;
      lfsr_d    = lfsr_q;
      target_d  = target_q;
      if (valid_i) begin
         sym_d = inject ? (sym_i ^ bit_mask_i) : sym_i;
      end
      if (clr_i) begin
         pos_d     = '0;
         inj_cnt_d = '0;
         sym_cnt_d = '0;
      end else if (valid_i) begin
         pos_d = pos_q + 1'b1;
         if (win_start) begin
            mode_d = mode_i;
            blen_d = burst_len_i;
         end
         // The next window's offset is drawn as the current window closes.
         if (pos_q == POS_LAST) begin
            lfsr_d   = lfsr_step;
            target_d = lfsr_step[WIN_LOG2-1:0];
         end
         if (sym_cnt_q != CNT_MAX) sym_cnt_d = sym_cnt_q + 1'b1;
         if (inject && (inj_cnt_q != CNT_MAX)) inj_cnt_d = inj_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         sym_q     <= '0;
         err_q     <= 1'b0;
         inj_cnt_q <= '0;
         sym_cnt_q <= '0;
         pos_q     <= '0;
         mode_q    <= 2'd0;
         blen_q    <= '0;
         lfsr_q    <= SEED;
         target_q  <= SEED[WIN_LOG2-1:0];
      end else begin
         valid_q   <= valid_d;
         sym_q     <= sym_d;
         err_q     <= err_d;
         inj_cnt_q <= inj_cnt_d;
         sym_cnt_q <= sym_cnt_d;
         pos_q     <= pos_d;
         mode_q    <= mode_d;
         blen_q    <= blen_d;
         lfsr_q    <= lfsr_d;
         target_q  <= target_d;
      end
   end

   assign valid_o     = valid_q;
   assign sym_o       = sym_q;
   assign err_o       = err_q;
   assign inj_count_o = inj_cnt_q;
   assign sym_count_o = sym_cnt_q;

endmodule

// File: tb/tb_channel_error_injector.sv
// tb/tb_channel_error_injector.sv - randomized bench with a window-level reference model
module tb_channel_error_injector;

   localparam logic [15:0] TB_SEED = 16'hACEE;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr_i = 1'b0;
   logic       valid_i = 1'b0;
   logic [1:0] sym_i = 2'b00;
   logic [1:0] mode_i = 2'd0;
   logic [1:0] bit_mask_i = 2'b00;
   logic [3:0] burst_len_i = 4'd0;

   logic        valid_o, err_o, valid_s, err_s;
   logic [1:0]  sym_o, sym_s;
   logic [15:0] inj_count_o, sym_count_o;
   logic [3:0]  inj_count_s, sym_count_s;

   int n_chk = 0;
   int n_fail = 0;

   int         m_pos, m_mode, m_blen, m_target, m_sym, m_inj;
   logic [15:0] m_lfsr;
   logic       exp_valid, exp_err;
   logic [1:0] exp_sym;

   always #5 clk = ~clk;

   channel_error_injector #(.SYM_W(2), .WIN_LOG2(4), .CNT_W(16), .LFSR_SEED(TB_SEED)) dut (
      .clk(clk), .rst(rst), .clr_i(clr_i), .valid_i(valid_i), .sym_i(sym_i),
      .mode_i(mode_i), .bit_mask_i(bit_mask_i), .burst_len_i(burst_len_i),
      .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
      .inj_count_o(inj_count_o), .sym_count_o(sym_count_o));

   channel_error_injector #(.SYM_W(2), .WIN_LOG2(4), .CNT_W(4), .LFSR_SEED(TB_SEED)) dut_s (
      .clk(clk), .rst(rst), .clr_i(clr_i), .valid_i(valid_i), .sym_i(sym_i),
      .mode_i(mode_i), .bit_mask_i(bit_mask_i), .burst_len_i(burst_len_i),
      .valid_o(valid_s), .sym_o(sym_s), .err_o(err_s),
      .inj_count_o(inj_count_s), .sym_count_o(sym_count_s));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   // Right-shift Galois form of x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
   endfunction

   task automatic model_reset();
      m_pos = 0; m_mode = 0; m_blen = 0; m_sym = 0; m_inj = 0;
      m_lfsr = TB_SEED;
      m_target = int'(TB_SEED & 16'h000F);
      exp_valid = 1'b0; exp_err = 1'b0; exp_sym = 2'b00;
   endtask

   task automatic model_step(input bit v, input logic [1:0] s, input logic [1:0] m,
                             input logic [1:0] mk, input logic [3:0] bl, input bit c);
      bit selected;
      exp_valid = v;
      exp_err = 1'b0;
      if (c) begin
         if (v) exp_sym = s;
         m_pos = 0; m_sym = 0; m_inj = 0;
      end else if (v) begin
         if (m_pos == 0) begin
            m_mode = int'(m); m_blen = int'(bl);
         end
         case (m_mode)
            1: selected = (m_pos == 15);
            2: selected = (m_pos == m_target);
            3: selected = (m_pos >= m_target) && (m_pos < m_target + m_blen);
            default: selected = 1'b0;
         endcase
         exp_err = selected && (mk != 2'b00);
         exp_sym = exp_err ? (s ^ mk) : s;
         m_sym++;
         if (exp_err) m_inj++;
         if (m_pos == 15) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_target = int'(m_lfsr & 16'h000F);
         end
         m_pos = (m_pos + 1) % 16;
      end
   endtask

   task automatic check_outputs();
      check("valid_o", valid_o, exp_valid);
      check("sym_o", sym_o, exp_sym);
      check("err_o", err_o, exp_err);
      check("sym_count_o", sym_count_o, sat(m_sym, 65535));
      check("inj_count_o", inj_count_o, sat(m_inj, 65535));
      check("sym_o_small", sym_s, exp_sym);
      check("sym_count_small", sym_count_s, sat(m_sym, 15));
      check("inj_count_small", inj_count_s, sat(m_inj, 15));
      if (!valid_o) check("err_without_valid", err_o, 1'b0);
   endtask

   task automatic cycle(input bit v, input logic [1:0] s, input logic [1:0] m,
                        input logic [1:0] mk, input logic [3:0] bl, input bit c);
      valid_i = v; sym_i = s; mode_i = m; bit_mask_i = mk; burst_len_i = bl; clr_i = c;
      @(posedge clk);
      model_step(v, s, m, mk, bl, c);
      @(negedge clk);
      check_outputs();
   endtask

   // Asserts reset between edges and checks the asynchronous clear before any clock edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      valid_i = 1'b0; clr_i = 1'b0;
      #1;
      model_reset();
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_sym_o", sym_o, 2'b00);
      check("rst_err_o", err_o, 1'b0);
      check("rst_sym_count", sym_count_o, 16'd0);
      check("rst_inj_count", inj_count_o, 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int errs;
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 10; i++) cycle(1'b1, 2'($urandom), 2'd0, 2'b11, 4'd0, 1'b0);
      do_reset();
      cycle(1'b1, 2'b11, 2'd0, 2'b11, 4'd0, 1'b0);
      check("post_rst_sym", sym_o, 2'b11);
      check("post_rst_count", sym_count_o, 16'd1);

      do_reset();
      for (int p = 0; p < 16; p++) cycle(1'b1, 2'($urandom), 2'd3, 2'b01, 4'd3, 1'b0);
      check("burst_clipped", inj_count_o, 16'd2);
      for (int p = 0; p < 16; p++) cycle(1'b1, 2'($urandom), 2'd3, 2'b01, 4'd0, 1'b0);
      check("burst_len0", inj_count_o, 16'd2);
      for (int p = 0; p < 16; p++)
         cycle(1'b1, 2'($urandom), (p < 5) ? 2'd1 : 2'd0, 2'b01, 4'd0, 1'b0);
      check("mode_latched", inj_count_o, 16'd3);

      do_reset();
      for (int i = 0; i < 64; i++) cycle(1'b1, 2'b00, 2'd1, 2'b10, 4'd0, 1'b0);
      check("periodic_inj", inj_count_o, 16'd4);
      check("periodic_sym", sym_count_o, 16'd64);
      check("small_saturated", sym_count_s, 4'd15);

      for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 2'd1, 2'b10, 4'd0, 1'b0);
      cycle(1'b1, 2'b01, 2'd1, 2'b10, 4'd0, 1'b1);
      check("clr_unmodified", sym_o, 2'b01);
      check("clr_no_err", err_o, 1'b0);
      check("clr_counts", sym_count_o, 16'd0);
      for (int i = 0; i < 16; i++) cycle(1'b1, 2'b00, 2'd1, 2'b10, 4'd0, 1'b0);
      check("clr_restart_pos", inj_count_o, 16'd1);

      for (int i = 0; i < 32; i++) cycle(i % 2 == 0, 2'($urandom), 2'd1, 2'b11, 4'd0, 1'b0);
      cycle(1'b0, 2'b00, 2'd1, 2'b00, 4'd0, 1'b1);
      for (int i = 0; i < 32; i++) cycle(1'b1, 2'($urandom), 2'd1, 2'b00, 4'd0, 1'b0);
      check("mask_zero_inj", inj_count_o, 16'd0);

      cycle(1'b0, 2'b00, 2'd2, 2'b01, 4'd0, 1'b1);
      for (int w = 0; w < 1024; w++) begin
         errs = 0;
         for (int p = 0; p < 16; p++) begin
            cycle(1'b1, 2'($urandom), 2'd2, 2'b01, 4'd0, 1'b0);
            if (err_o) errs++;
         end
         check("one_err_per_window", errs, 1);
      end
      check("random_window_inj", inj_count_o, 16'd1024);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 2'($urandom),
               4'($urandom), $urandom_range(0, 31) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
